// File: rtl/control_word_loader.sv
// Purpose: sync + debounce a load push-button and raw switches into a clean control-word load (data_out + load_en).
// Latency: button first sampled high at edge k -> LOAD entered at edge k+1+DEBOUNCE_CYCLES, load_en high the cycle after.
// Backpressure: none; the control register always accepts, so load_en is a free-running one-cycle strobe.
// Optional macro CONTROL_LOADER_AUTO_REPEAT_EN: held button re-loads every REPEAT_CYCLES+1 clocks.
module control_word_loader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             button,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] data_out,
  output logic             load_en,
  output logic             busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_ONE  = CW'(1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES);

  // Reject nonsensical parameterisations at elaboration.
  if (WIDTH < 1 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20) || REPEAT_CYCLES < 1) begin : g_param_check
    $error("control_word_loader: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    LOAD,
    HELD,
    RELEASE_DB
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
  logic             btn_meta, btn_s;
  logic [WIDTH-1:0] sw_meta, sw_s;

`ifdef CONTROL_LOADER_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_ONE  = RW'(1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES);
  logic [RW-1:0] rpt, rpt_nxt, rpt_inc;
`endif

  // Two-flop synchronisers for the asynchronous button and switch inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      btn_meta <= button;
      btn_s    <= btn_meta;
      sw_meta  <= switches;
      sw_s     <= sw_meta;
    end
  end

  // State, debounce counter and repeat counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
`ifdef CONTROL_LOADER_AUTO_REPEAT_EN
      rpt   <= '0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
`ifdef CONTROL_LOADER_AUTO_REPEAT_EN
      rpt   <= rpt_nxt;
`endif
    end
  end

  // Capture the synchronised switches on every edge that enters LOAD.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if (state_nxt == LOAD) begin
      data_out <= sw_s;
    end
  end

  // Next-state and output decode; counters default to cleared so any exit or level break resets them.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    cnt_inc   = cnt + DB_ONE;
    load_en   = (state == LOAD);
    busy      = (state != IDLE);
`ifdef CONTROL_LOADER_AUTO_REPEAT_EN
    rpt_nxt   = '0;
    rpt_inc   = rpt + RPT_ONE;
`endif
    case (state)
      IDLE: begin
        if (btn_s) begin
          if (DB_ONE == DB_LAST) begin
            state_nxt = LOAD;
          end else begin
            state_nxt = PRESS_DB;
            cnt_nxt   = DB_ONE;
          end
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt_inc == DB_LAST) begin
          state_nxt = LOAD;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      LOAD: begin
        state_nxt = HELD;
      end
      HELD: begin
        if (!btn_s) begin
          if (DB_ONE == DB_LAST) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = RELEASE_DB;
            cnt_nxt   = DB_ONE;
          end
        end
`ifdef CONTROL_LOADER_AUTO_REPEAT_EN
        else if (rpt_inc == RPT_LAST) begin
          state_nxt = LOAD;
        end else begin
          rpt_nxt = rpt_inc;
        end
`endif
      end
      RELEASE_DB: begin
        if (btn_s) begin
          state_nxt = HELD;
        end else if (cnt_inc == DB_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_word_loader.sv
// Bench for control_word_loader with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, WIDTH=4.
// Expected loads (value + edge number) are queued as stimulus is driven and matched against load_en strobes.
// Also watches for back-to-back strobes, data_out changing without a strobe, and busy timing.
module tb_control_word_loader;

  localparam int W   = 4;
  localparam int DB  = 4;
  localparam int RPT = 8;
`ifdef CONTROL_LOADER_AUTO_REPEAT_EN
  localparam bit RPT_ON = 1'b1;
`else
  localparam bit RPT_ON = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic         button;
  logic [W-1:0] switches;
  logic [W-1:0] data_out;
  logic         load_en;
  logic         busy;

  typedef struct {
    logic [W-1:0] dat;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc   = 0;
  logic         prev_load = 1'b0;
  logic [W-1:0] prev_data = '0;

  control_word_loader #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .button  (button),
    .switches(switches),
    .data_out(data_out),
    .load_en (load_en),
    .busy    (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Queue the strobe(s) a press should produce: raw high first sampled at edge k for hold edges.
  task automatic push_press(input logic [W-1:0] d, input int k, input int hold);
    exp_t e;
    int   l;
    l = k + 1 + DB;
    e.dat = d;
    e.cyc = l;
    sb.push_back(e);
    if (RPT_ON) begin
      while (l + RPT + 1 <= k + hold + 1) begin
        l += RPT + 1;
        e.cyc = l;
        sb.push_back(e);
      end
    end
  endtask

  // Advance one clock edge and check the outputs 1ns later.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    cyc++;
    #1;
    chk("double_strobe", {31'b0, load_en & prev_load}, 32'd0);
    if (load_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_load", {31'b0, load_en}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("load_cycle", cyc, e.cyc);
        chk("load_data", {28'b0, data_out}, {28'b0, e.dat});
      end
    end else begin
      if (reset) chk("data_hold", {28'b0, data_out}, {28'b0, prev_data});
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        chk("missed_load", {31'b0, load_en}, 32'd1);
        void'(sb.pop_front());
      end
    end
    prev_load = load_en;
    prev_data = data_out;
  endtask

  // Clean press: hold for 'hold' edges, release, wait for the release debounce.
  task automatic press(input logic [W-1:0] sw, input int hold);
    int k;
    switches = sw;
    button   = 1'b1;
    k        = cyc + 1;
    push_press(sw, k, hold);
    repeat (hold) tick();
    chk("busy_while_held", {31'b0, busy}, 32'd1);
    button = 1'b0;
    repeat (DB + 4) tick();
    chk("idle_after_release", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int           k;
    int           f;
    logic [4:0]   pat;
    reset    = 1'b1;
    button   = 1'b1;
    switches = 4'hA;
    #1 reset = 1'b0;

    // Reset held with button pressed: everything quiet.
    repeat (3) tick();
    chk("rst_data", {28'b0, data_out}, 32'd0);
    chk("rst_load", {31'b0, load_en}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);

    // Release reset with button already held: full debounce, load 0xA 6 edges later.
    reset = 1'b1;
    k = cyc + 1;
    push_press(4'hA, k, 10);
    repeat (10) tick();
    button = 1'b0;
    repeat (DB + 4) tick();
    chk("rst_release_idle", {31'b0, busy}, 32'd0);

    // Clean press, long hold.
    press(4'h5, 40);

    // Bouncy press: 1,0,1,1,0 then steady high.
    pat      = 5'b01101;
    switches = 4'h6;
    for (int i = 0; i < 5; i++) begin
      button = pat[i];
      tick();
    end
    button = 1'b1;
    k = cyc + 1;
    push_press(4'h6, k, 20);
    repeat (20) tick();
    button = 1'b0;
    repeat (DB + 4) tick();
    chk("bounce_idle", {31'b0, busy}, 32'd0);

    // Release bounce: low 2, high 3, then low for good.
    switches = 4'h9;
    button   = 1'b1;
    k = cyc + 1;
    push_press(4'h9, k, 8);
    repeat (8) tick();
    button = 1'b0;
    repeat (2) tick();
    button = 1'b1;
    repeat (3) tick();
    button = 1'b0;
    f = cyc + 1;
    repeat (5) tick();
    chk("rel_busy_before", {31'b0, busy}, 32'd1);
    chk("rel_cycle_before", cyc, f + 4);
    tick();
    chk("rel_busy_after", {31'b0, busy}, 32'd0);
    repeat (3) tick();

    // Switch isolation: change switches while held.
    switches = 4'h3;
    button   = 1'b1;
    k = cyc + 1;
    push_press(4'h3, k, 8);
    repeat (7) tick();
    switches = 4'hC;
    tick();
    button = 1'b0;
    repeat (DB + 4) tick();
    chk("iso_data_kept", {28'b0, data_out}, 32'h3);
    press(4'hC, 8);
    chk("iso_next_load", {28'b0, data_out}, 32'hC);

    // Reset mid-debounce aborts; held button then needs a full new debounce.
    switches = 4'hE;
    button   = 1'b1;
    repeat (3) tick();
    chk("mid_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_data", {28'b0, data_out}, 32'd0);
    chk("mid_rst_load", {31'b0, load_en}, 32'd0);
    tick();
    reset = 1'b1;
    k = cyc + 1;
    push_press(4'hE, k, 10);
    repeat (10) tick();
    button = 1'b0;
    repeat (DB + 4) tick();

    // Long hold with 0x7 (repeat strobes every 9 edges when the feature is built in).
    press(4'h7, 40);

    repeat (5) tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
